// File: rtl/hamming_rx.sv
// Serial Hamming(7,4) frame receiver: collects BLOCKS 7-bit code blocks,
// corrects single-bit errors per block and presents the word with error flags.
module hamming_rx #(
   parameter int WIDTH = 32,
   localparam int BLOCKS = WIDTH / 4,
   localparam int FRAME_BITS = 7 * BLOCKS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        in_start,
   input  logic                        serial_in,
   output logic                        in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            parallel_out,
   output logic [BLOCKS-1:0]           err_mask,
   output logic [BLOCKS-1:0]           data_err_mask,
   output logic [$clog2(BLOCKS+1)-1:0] err_count,
   output logic                        abort
);

   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam int ECNT_W = $clog2(BLOCKS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DECODE, OUT} state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [FRAME_BITS-1:0]   buf_reg, buf_next;
   logic                    abort_reg, abort_next;
   logic                    load_out;
   logic [WIDTH-1:0]        data_reg;
   logic [BLOCKS-1:0]       err_reg, derr_reg;
   logic [ECNT_W-1:0]       ecnt_reg;

   logic [WIDTH-1:0]        dec_data;
   logic [BLOCKS-1:0]       dec_err, dec_derr;
   logic [ECNT_W-1:0]       dec_count;

   // Per-block decode; block bits in frame order are d0,d1,d2,d3,p1,p2,p3.
   for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_block
      logic [6:0] cw;
      logic [2:0] syn;
      logic [3:0] flip;

      assign cw = buf_reg[7*gi +: 7];
      assign syn[0] = cw[4] ^ cw[3] ^ cw[2] ^ cw[0];
      assign syn[1] = cw[5] ^ cw[3] ^ cw[1] ^ cw[0];
      assign syn[2] = cw[6] ^ cw[2] ^ cw[1] ^ cw[0];

      always_comb begin
         flip = 4'b0000;
         case (syn)
            3'b111:  flip = 4'b0001;
            3'b110:  flip = 4'b0010;
            3'b101:  flip = 4'b0100;
            3'b011:  flip = 4'b1000;
            default: flip = 4'b0000;
         endcase
      end

      assign dec_data[4*gi +: 4] = cw[3:0] ^ flip;
      assign dec_err[gi]         = |syn;
      assign dec_derr[gi]        = |flip;
   end

   always_comb begin
      dec_count = '0;
      for (int i = 0; i < BLOCKS; i++) begin
         dec_count = dec_count + ECNT_W'(dec_err[i]);
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      buf_next   = buf_reg;
      abort_next = 1'b0;
      load_out   = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && in_start) begin
               buf_next    = '0;
               buf_next[0] = serial_in;
               cnt_next    = CNT_W'(1);
               state_next  = SHIFT;
            end
         end
         SHIFT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_start) begin
                  // Restart wins over the partial frame, even on its last bit.
                  buf_next    = '0;
                  buf_next[0] = serial_in;
                  cnt_next    = CNT_W'(1);
                  abort_next  = 1'b1;
               end else begin
                  buf_next[cnt_reg] = serial_in;
                  if (cnt_reg == LAST_BIT) begin
                     cnt_next   = '0;
                     state_next = DECODE;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
         end
         DECODE: begin
            load_out   = 1'b1;
            state_next = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         buf_reg   <= '0;
         abort_reg <= 1'b0;
         data_reg  <= '0;
         err_reg   <= '0;
         derr_reg  <= '0;
         ecnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         buf_reg   <= buf_next;
         abort_reg <= abort_next;
         if (load_out) begin
            data_reg <= dec_data;
            err_reg  <= dec_err;
            derr_reg <= dec_derr;
            ecnt_reg <= dec_count;
         end
      end
   end

   assign parallel_out  = data_reg;
   assign err_mask      = err_reg;
   assign data_err_mask = derr_reg;
   assign err_count     = ecnt_reg;
   assign abort         = abort_reg;

endmodule

// File: tb/tb_hamming_rx.sv
// Bench for hamming_rx: frames are built by an encoder with known injected
// bit flips, so the expected word and error masks follow from the injections.
module tb_hamming_rx;

   localparam int W  = 32;
   localparam int B  = W / 4;
   localparam int F  = 7 * B;
   localparam int CW = $clog2(B + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_start = 1'b0;
   logic          serial_in = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, abort;
   logic [W-1:0]  parallel_out;
   logic [B-1:0]  err_mask, data_err_mask;
   logic [CW-1:0] err_count;

   int total = 0;
   int bad = 0;
   int abort_cnt = 0;

   hamming_rx #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
      .serial_in(serial_in), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .parallel_out(parallel_out), .err_mask(err_mask),
      .data_err_mask(data_err_mask), .err_count(err_count), .abort(abort)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (abort === 1'b1) abort_cnt++;

   function automatic logic [F-1:0] encode(input logic [W-1:0] w);
      logic [F-1:0] f;
      logic [3:0]   d;
      f = '0;
      for (int b = 0; b < B; b++) begin
         d = w[4*b +: 4];
         f[7*b +: 7] = {d[0]^d[1]^d[2], d[0]^d[1]^d[3], d[0]^d[2]^d[3], d};
      end
      return f;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [F-1:0] f, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid  = 1'b0;
            in_start  = 1'($urandom);
            serial_in = 1'($urandom);
            tick();
         end
         in_valid  = 1'b1;
         in_start  = (i == 0);
         serial_in = f[i];
         tick();
      end
      in_valid = 1'b0;
      in_start = 1'b0;
   endtask

   // Called right after the edge that took the last frame bit.
   task automatic expect_word(input logic [W-1:0] w, input logic [B-1:0] em,
                              input logic [B-1:0] dem, input int hold, input string tag);
      check({tag, ".decode_gap"}, out_valid, 1'b0);
      tick();
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".in_ready"}, in_ready, 1'b0);
      check({tag, ".data"}, parallel_out, w);
      check({tag, ".err_mask"}, err_mask, em);
      check({tag, ".data_err_mask"}, data_err_mask, dem);
      check({tag, ".err_count"}, err_count, $countones(em));
      for (int h = 0; h < hold; h++) begin
         in_valid  = 1'b1;
         in_start  = 1'($urandom);
         serial_in = 1'($urandom);
         out_ready = 1'b0;
         tick();
         check({tag, ".hold"}, {out_valid, in_ready, parallel_out, err_mask, data_err_mask},
               {1'b1, 1'b0, w, em, dem});
      end
      in_valid  = 1'b0;
      in_start  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".accepted"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".outs"}, {out_valid, abort, parallel_out, err_mask, data_err_mask, err_count},
            '0);
      check({tag, ".in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [F-1:0] f;
      logic [W-1:0] w;
      logic [B-1:0] em, dem;
      int a0, p;

      rst = 1'b0;
      repeat (3) tick();
      check_cleared("reset");
      rst = 1'b1;
      tick();
      check_cleared("reset_release");

      // All-zero clean frame.
      send_bits(encode('0), F, 1'b0);
      expect_word('0, '0, '0, 0, "zeros");

      // Block 3 d1 flipped.
      f = encode(32'h5555_5555);
      f[7*3 + 1] ^= 1'b1;
      send_bits(f, F, 1'b0);
      expect_word(32'h5555_5555, 8'h08, 8'h08, 0, "blk3_d1");

      // Block 0 p2 and block 7 d3 flipped.
      f = encode(32'h5555_5555);
      f[7*0 + 5] ^= 1'b1;
      f[7*7 + 3] ^= 1'b1;
      send_bits(f, F, 1'b0);
      expect_word(32'h5555_5555, 8'h81, 8'h80, 0, "p2_d3");

      // Restart at bit 20, then a full clean frame.
      a0 = abort_cnt;
      send_bits(encode(32'h5555_5555), 20, 1'b0);
      check("restart.no_abort_yet", abort_cnt - a0, 0);
      send_bits(encode(32'h5555_5555), F, 1'b0);
      check("restart.abort_once", abort_cnt - a0, 1);
      expect_word(32'h5555_5555, '0, '0, 0, "restart");

      // Consumer stalls 10 cycles while serial input keeps toggling.
      w = $urandom;
      send_bits(encode(w), F, 1'b0);
      expect_word(w, '0, '0, 10, "stall");

      // Reset mid-frame.
      send_bits(encode(32'hDEAD_BEEF), 30, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_cleared("rst_midframe");

      // Reset while the word is being presented.
      send_bits(encode(32'hCAFE_F00D), F, 1'b0);
      tick();
      check("rst_out.valid_before", out_valid, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_cleared("rst_out");
      w = 32'h1234_5678;
      send_bits(encode(w), F, 1'b0);
      expect_word(w, '0, '0, 0, "after_rst");

      // Random words with at most one injected flip per block.
      a0 = abort_cnt;
      for (int n = 0; n < 25; n++) begin
         w   = $urandom;
         f   = encode(w);
         em  = '0;
         dem = '0;
         for (int b = 0; b < B; b++) begin
            p = $urandom_range(0, 9);
            if (p < 7) begin
               f[7*b + p] ^= 1'b1;
               em[b] = 1'b1;
               if (p < 4) dem[b] = 1'b1;
            end
         end
         repeat ($urandom_range(0, 2)) begin
            in_valid  = 1'b1;
            in_start  = 1'b0;
            serial_in = 1'($urandom);
            tick();
         end
         send_bits(f, F, 1'b1);
         expect_word(w, em, dem, $urandom_range(0, 3), "rand");
      end
      check("rand.no_abort", abort_cnt - a0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
